// File: rtl/fir_pkt_src_pkg.sv
// Shared types and width helpers for the FIR packet source.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } pkt_state_t;

  localparam int unsigned DEF_DATA_WIDTH = 16;

  // Reference layout of one buffered beat; modules rebuild it at their own width.
  typedef struct packed {
    logic                      last;
    logic [DEF_DATA_WIDTH-1:0] data;
  } fifo_entry_t;

  function automatic int unsigned entry_width(input int unsigned data_width);
    return data_width + 1;
  endfunction

  function automatic int unsigned beat_cnt_width(input int unsigned pkt_len);
    return $clog2(pkt_len);
  endfunction

endpackage

// File: rtl/fir_pkt_src_if.sv
// AXI-stream style beat channel between the packet source and the FIR top.
interface fir_pkt_src_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TLAST;
  logic                  TVALID;
  logic                  TREADY;

  modport master (output TDATA, TLAST, TVALID, input TREADY);
  modport slave  (input TDATA, TLAST, TVALID, output TREADY);
endinterface

// File: rtl/fir_pkt_src_fifo.sv
// First-word-fall-through FIFO; DEPTH counts the output register plus DEPTH-1 RAM slots.
module fir_sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned MEM_DEPTH = DEPTH - 1;
  localparam int unsigned PW        = $clog2(DEPTH);
  localparam int unsigned LW        = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [MEM_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, mem_cnt;
  logic             load_out, from_mem, bypass, mem_wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MEM_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The output register refills from RAM first; an empty RAM lets a push land there directly.
  always_comb begin
    load_out = !dout_valid || pop;
    from_mem = load_out && (mem_cnt != '0);
    bypass   = load_out && (mem_cnt == '0) && push;
    mem_wr   = push && !bypass;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (mem_wr)   wr_ptr <= ptr_inc(wr_ptr);
      if (from_mem) rd_ptr <= ptr_inc(rd_ptr);
      mem_cnt <= mem_cnt + PW'(mem_wr) - PW'(from_mem);
      if (load_out) begin
        dout_valid <= from_mem || bypass;
        if (from_mem)    dout <= mem[rd_ptr];
        else if (bypass) dout <= din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= din;
  end

  assign level = LW'(mem_cnt) + LW'(dout_valid);

endmodule

// File: rtl/fir_pkt_src.sv
// Packet framing source for the FIR S_AXIS port: buffers a valid-only stream into PKT_LEN-beat packets.
// Optional internal ramp generator enabled by defining FIR_PKT_SRC_BIST_EN (adds BIST_MODE input).
module fir_pkt_src
  import fir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PKT_LEN    = 64,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                   CLK,
  input  logic                   ARESETN,
  input  logic                   ENABLE,
  input  logic                   SAMPLE_VALID,
  input  logic [DATA_WIDTH-1:0]  SAMPLE_DATA,
`ifdef FIR_PKT_SRC_BIST_EN
  input  logic                   BIST_MODE,
`endif
  fir_pkt_src_if.master          M_AXIS,
  input  logic                   CLEAR_STATUS,
  output logic                   OVERFLOW,
  output logic [CNT_WIDTH-1:0]   DROP_COUNT,
  output logic [$clog2(DEPTH):0] FILL_LEVEL
);

  localparam int unsigned BW = beat_cnt_width(PKT_LEN);
  localparam int unsigned EW = entry_width(DATA_WIDTH);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  pkt_state_t            state, state_nxt;
  logic [BW-1:0]         beat_cnt, beat_nxt;
  logic                  capture, level_ok, attempt, wr_en, drop, last_beat;
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  entry_t                wr_entry, rd_entry;
  logic                  tvalid;

  assign capture   = (state != IDLE);
  assign level_ok  = (FILL_LEVEL < LW'(DEPTH));
  assign last_beat = (beat_cnt == BW'(PKT_LEN - 1));

`ifdef FIR_PKT_SRC_BIST_EN
  logic [DATA_WIDTH-1:0] ramp;

  always_comb begin
    src_valid = BIST_MODE ? level_ok : SAMPLE_VALID;
    src_data  = BIST_MODE ? ramp : SAMPLE_DATA;
  end

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN)                ramp <= '0;
    else if (wr_en && BIST_MODE) ramp <= ramp + 1'b1;
  end
`else
  assign src_valid = SAMPLE_VALID;
  assign src_data  = SAMPLE_DATA;
`endif

  always_comb begin
    attempt  = src_valid && capture;
    wr_en    = attempt && level_ok;
    drop     = attempt && !level_ok;
    beat_nxt = beat_cnt;
    if (wr_en) beat_nxt = last_beat ? '0 : beat_cnt + 1'b1;
    wr_entry = '{last: last_beat, data: src_data};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (ENABLE) state_nxt = RUN;
      RUN:      if (!ENABLE) state_nxt = (beat_nxt == '0) ? IDLE : STOPPING;
      STOPPING: if (wr_en && last_beat) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // A drop coinciding with a clear restarts the count at one rather than zero.
  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      OVERFLOW   <= 1'b0;
      DROP_COUNT <= '0;
    end else if (drop) begin
      OVERFLOW <= 1'b1;
      if (CLEAR_STATUS)     DROP_COUNT <= CNT_WIDTH'(1);
      else if (!(&DROP_COUNT)) DROP_COUNT <= DROP_COUNT + 1'b1;
    end else if (CLEAR_STATUS) begin
      OVERFLOW   <= 1'b0;
      DROP_COUNT <= '0;
    end
  end

  fir_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (ARESETN),
    .push       (wr_en),
    .din        (wr_entry),
    .pop        (tvalid && M_AXIS.TREADY),
    .dout       (rd_entry),
    .dout_valid (tvalid),
    .level      (FILL_LEVEL)
  );

  assign M_AXIS.TVALID = tvalid;
  assign M_AXIS.TDATA  = rd_entry.data;
  assign M_AXIS.TLAST  = rd_entry.last;

endmodule

// File: tb/tb_fir_pkt_src.sv
// Directed bench for fir_pkt_src with DATA_WIDTH=16, PKT_LEN=4, DEPTH=8.
module tb_fir_pkt_src;

  localparam int unsigned DW = 16;
  localparam int unsigned PL = 4;
  localparam int unsigned DP = 8;
  localparam int unsigned CW = 16;

  logic          CLK          = 1'b0;
  logic          ARESETN      = 1'b1;
  logic          ENABLE       = 1'b0;
  logic          SAMPLE_VALID = 1'b0;
  logic [DW-1:0] SAMPLE_DATA  = '0;
  logic          CLEAR_STATUS = 1'b0;
  logic          OVERFLOW;
  logic [CW-1:0] DROP_COUNT;
  logic [3:0]    FILL_LEVEL;
`ifdef FIR_PKT_SRC_BIST_EN
  logic          BIST_MODE    = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  logic [16:0] mon_q [$];

  fir_pkt_src_if #(.DATA_WIDTH(DW)) axis ();

  fir_pkt_src #(
    .DATA_WIDTH (DW),
    .PKT_LEN    (PL),
    .DEPTH      (DP),
    .CNT_WIDTH  (CW)
  ) dut (
    .CLK          (CLK),
    .ARESETN      (ARESETN),
    .ENABLE       (ENABLE),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE_DATA  (SAMPLE_DATA),
`ifdef FIR_PKT_SRC_BIST_EN
    .BIST_MODE    (BIST_MODE),
`endif
    .M_AXIS       (axis),
    .CLEAR_STATUS (CLEAR_STATUS),
    .OVERFLOW     (OVERFLOW),
    .DROP_COUNT   (DROP_COUNT),
    .FILL_LEVEL   (FILL_LEVEL)
  );

  always #5 CLK = ~CLK;

  // Inputs change just after posedge, so a negedge snapshot shows what the next edge pops.
  always @(negedge CLK) begin
    if (ARESETN && axis.TVALID && axis.TREADY)
      mon_q.push_back({axis.TLAST, axis.TDATA});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected beats are first, first+1, ...; every fourth beat carries TLAST.
  task automatic chk_stream(input string tag, input logic [15:0] first, input int n);
    logic [16:0] e;
    logic [16:0] o;
    chk({tag, "_len"}, mon_q.size(), n);
    for (int i = 0; i < n; i++) begin
      e = {(i % 4 == 3), first + 16'(i)};
      o = (i < mon_q.size()) ? mon_q[i] : 'x;
      chk($sformatf("%s_beat%0d", tag, i), {15'b0, o}, {15'b0, e});
    end
    mon_q.delete();
  endtask

  initial begin
    axis.TREADY = 1'b0;

    // Reset state
    #1 ARESETN = 1'b0;
    #1;
    chk("rst_tvalid", axis.TVALID, 0);
    chk("rst_tdata",  axis.TDATA,  0);
    chk("rst_tlast",  axis.TLAST,  0);
    chk("rst_ovf",    OVERFLOW,    0);
    chk("rst_drop",   DROP_COUNT,  0);
    chk("rst_fill",   FILL_LEVEL,  0);
    step();
    step();
    ARESETN = 1'b1;

    // Basic framing; the IDLE cycle must not capture
    ENABLE       = 1'b1;
    axis.TREADY  = 1'b1;
    SAMPLE_VALID = 1'b1;
    SAMPLE_DATA  = 16'hdead;
    step();
    chk("idle_fill",   FILL_LEVEL,  0);
    chk("idle_tvalid", axis.TVALID, 0);
    SAMPLE_DATA = 16'h0001;
    step();
    chk("lat_tvalid", axis.TVALID, 1);
    chk("lat_tdata",  axis.TDATA,  16'h0001);
    chk("lat_fill",   FILL_LEVEL,  1);
    for (int d = 2; d <= 8; d++) begin
      SAMPLE_DATA = 16'(d);
      step();
    end
    SAMPLE_VALID = 1'b0;
    repeat (4) step();
    chk_stream("basic", 16'h0001, 8);
    chk("basic_fill", FILL_LEVEL, 0);

    // Backpressure and overflow
    axis.TREADY  = 1'b0;
    SAMPLE_VALID = 1'b1;
    for (int i = 0; i < 12; i++) begin
      SAMPLE_DATA = 16'h0010 + 16'(i);
      step();
    end
    SAMPLE_VALID = 1'b0;
    chk("bp_fill",   FILL_LEVEL,  8);
    chk("bp_ovf",    OVERFLOW,    1);
    chk("bp_drop",   DROP_COUNT,  4);
    chk("bp_hold_d", axis.TDATA,  16'h0010);
    chk("bp_hold_l", axis.TLAST,  0);
    chk("bp_tvalid", axis.TVALID, 1);
    axis.TREADY = 1'b1;
    repeat (10) step();
    chk_stream("bp", 16'h0010, 8);
    chk("bp_fill_end", FILL_LEVEL, 0);

    // Status clear, then clear racing a drop
    CLEAR_STATUS = 1'b1;
    step();
    CLEAR_STATUS = 1'b0;
    chk("clr_ovf",  OVERFLOW,   0);
    chk("clr_drop", DROP_COUNT, 0);
    axis.TREADY  = 1'b0;
    SAMPLE_VALID = 1'b1;
    for (int i = 0; i < 11; i++) begin
      SAMPLE_DATA = 16'h0050 + 16'(i);
      step();
    end
    chk("race_pre_drop", DROP_COUNT, 3);
    SAMPLE_DATA  = 16'h005b;
    CLEAR_STATUS = 1'b1;
    step();
    CLEAR_STATUS = 1'b0;
    SAMPLE_VALID = 1'b0;
    chk("race_drop", DROP_COUNT, 1);
    chk("race_ovf",  OVERFLOW,   1);
    axis.TREADY = 1'b1;
    repeat (10) step();
    chk_stream("race", 16'h0050, 8);
    CLEAR_STATUS = 1'b1;
    step();
    CLEAR_STATUS = 1'b0;

    // Stop mid-packet finishes on the boundary, then ignores input
    SAMPLE_VALID = 1'b1;
    SAMPLE_DATA  = 16'h0021;
    step();
    SAMPLE_DATA  = 16'h0022;
    step();
    SAMPLE_VALID = 1'b0;
    ENABLE       = 1'b0;
    step();
    SAMPLE_VALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      SAMPLE_DATA = 16'h0023 + 16'(i);
      step();
    end
    SAMPLE_VALID = 1'b0;
    repeat (4) step();
    chk_stream("stop", 16'h0021, 4);
    chk("stop_drop", DROP_COUNT, 0);
    chk("stop_ovf",  OVERFLOW,   0);
    chk("stop_fill", FILL_LEVEL, 0);

    // Reset mid-packet
    ENABLE = 1'b1;
    step();
    axis.TREADY  = 1'b0;
    SAMPLE_VALID = 1'b1;
    SAMPLE_DATA  = 16'h0031;
    step();
    SAMPLE_DATA  = 16'h0032;
    step();
    SAMPLE_VALID = 1'b0;
    chk("mid_fill", FILL_LEVEL, 2);
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_tvalid", axis.TVALID, 0);
    chk("mid_rst_fill",   FILL_LEVEL,  0);
    chk("mid_rst_tdata",  axis.TDATA,  0);
    step();
    step();
    ARESETN = 1'b1;
    mon_q.delete();
    step();
    axis.TREADY  = 1'b1;
    SAMPLE_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      SAMPLE_DATA = 16'h0041 + 16'(i);
      step();
    end
    SAMPLE_VALID = 1'b0;
    repeat (4) step();
    chk_stream("rst", 16'h0041, 4);

`ifdef FIR_PKT_SRC_BIST_EN
    // Internal ramp source
    ENABLE = 1'b0;
    step();
    BIST_MODE = 1'b1;
    ENABLE    = 1'b1;
    step();
    repeat (7) step();
    ENABLE = 1'b0;
    step();
    repeat (4) step();
    BIST_MODE = 1'b0;
    chk_stream("bist", 16'h0000, 8);
    chk("bist_drop", DROP_COUNT, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_pkt_src.md
Name: fir_pkt_src

Overview:
- Upstream source stage for the FIR AXI-stream top. It feeds that top's S_AXIS slave port.
- Accepts a free-running sample stream with no backpressure (valid only), buffers it in a FIFO, and frames it into fixed-length packets with TLAST on the final beat of each packet.
- Drops samples on overflow and reports drops through status outputs.
- Starts and stops only on packet boundaries, so the downstream FIR never sees a truncated packet.

Parameters:
- DATA_WIDTH, 16, sample and TDATA width.
- PKT_LEN, 64, beats per packet; must be ≥2.
- DEPTH, 16, total buffer entries including the output register; must be a power of 2 and ≥2.
- CNT_WIDTH, 16, width of the drop counter.

Ports:
- CLK  in  1  clock, single domain.
- ARESETN  in  1  asynchronous active-low reset.
- ENABLE  in  1  level request to capture packets.
- SAMPLE_VALID  in  1  sample present this cycle; no ready is returned.
- SAMPLE_DATA  in  DATA_WIDTH  sample value.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TDATA  out  DATA_WIDTH  output data.
- M_AXIS_TLAST  out  1  last beat of packet.
- M_AXIS_TVALID  out  1  output valid.
- CLEAR_STATUS  in  1  one-cycle pulse; clears OVERFLOW and DROP_COUNT.
- OVERFLOW  out  1  sticky; a sample was dropped.
- DROP_COUNT  out  CNT_WIDTH  saturating count of dropped samples.
- FILL_LEVEL  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.

Behaviour:
- Reset (asynchronous, active-low, effective immediately):
  - M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0.
  - OVERFLOW=0, DROP_COUNT=0, FILL_LEVEL=0.
  - state=IDLE, beat count=0, FIFO contents discarded.
  - Reset asserted mid-packet abandons that packet; no partial TLAST is emitted afterwards.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE: no capture. ENABLE=1 → RUN; capture begins the following cycle.
  - RUN: capture. If ENABLE=0, compute next_count (beat count after this cycle's write). next_count==0 → IDLE; otherwise → STOPPING.
  - STOPPING: capture continues regardless of ENABLE. Go to IDLE in the cycle after the beat tagged last is written. Re-asserting ENABLE does not abort STOPPING.
- Capture: attempt = SAMPLE_VALID && state∈{RUN,STOPPING}.
  - Write when attempt && FILL_LEVEL<DEPTH.
  - FILL_LEVEL is the registered value. A write while FILL_LEVEL==DEPTH is dropped even if a pop occurs in the same cycle.
- Beat count:
  - Counts written beats 0..PKT_LEN-1.
  - A written entry carries last=1 when count==PKT_LEN-1; count then wraps to 0.
  - Dropped samples do not advance the count, so packets are always exactly PKT_LEN beats.
- Drop:
  - Sets OVERFLOW.
  - DROP_COUNT increments and saturates at all-ones.
  - CLEAR_STATUS in the same cycle as a drop: the drop wins (OVERFLOW=1, DROP_COUNT=1).
- Output handshake:
  - Write into an empty buffer → M_AXIS_TVALID=1 the next cycle (1-cycle latency, first-word-fall-through).
  - While TVALID && !TREADY, TDATA and TLAST are held stable.
  - A pop occurs on TVALID && TREADY. The next entry is presented in the following cycle, with no bubble when data is available.
- FILL_LEVEL:
  - +1 on write, −1 on pop, unchanged on simultaneous write and pop.
  - Counts the output register as an occupied entry.
- Ordering: strict FIFO order, no reordering.

Optional Feature:
- Macro: FIR_PKT_SRC_BIST_EN.
- Defined:
  - Adds input port BIST_MODE (1 bit).
  - When BIST_MODE=1, SAMPLE_VALID/SAMPLE_DATA are ignored. The internal source presents one sample every cycle whenever capture is active and FILL_LEVEL<DEPTH, so no drops are generated.
  - The source is a DATA_WIDTH-bit ramp: it starts at 0 after reset, increments per written beat, and wraps at all-ones.
  - BIST_MODE must only change while in IDLE; the ramp value is retained across IDLE.
- Not defined: port absent; ramp logic removed.

Decomposition:
- Package fir_pkg:
  - typedef enum pkt_state_t {IDLE, RUN, STOPPING}.
  - Packed struct fifo_entry_t {logic last; logic [DATA_WIDTH-1:0] data}, parameterised via a width function.
  - Localparam helper for beat-count width: $clog2(PKT_LEN).
- Sub-module fir_sync_fifo:
  - First-word-fall-through, DEPTH entries including the output register.
  - Provides push, pop, level, and registered output.
- fir_pkt_src holds the FSM, beat counter, drop/status logic and the optional ramp.

Test Plan:
All scenarios use DATA_WIDTH=16, PKT_LEN=4, DEPTH=8.
- Basic framing: ENABLE=1, TREADY=1, samples 0x0001..0x0008 on consecutive cycles → 8 beats in order; TLAST on 0x0004 and 0x0008; first TVALID one cycle after the first write.
- Backpressure/overflow: TREADY=0, 12 samples 0x0010..0x001B → FILL_LEVEL=8, OVERFLOW=1, DROP_COUNT=4. Releasing TREADY yields 0x0010..0x0017 with TLAST on 0x0013 and 0x0017.
- Boundary stop: ENABLE dropped after 2 beats of a packet → state STOPPING. Exactly 2 more samples are accepted (TLAST on the 4th), then IDLE; further samples are ignored and not counted as drops.
- Status clear race: CLEAR_STATUS pulsed in the same cycle as a drop with DROP_COUNT=3 → next cycle DROP_COUNT=1, OVERFLOW=1.
- Reset mid-packet: ARESETN low after 2 of 4 beats written → TVALID=0 and FILL_LEVEL=0 immediately. After release and ENABLE, the next packet has TLAST on its 4th beat.
- BIST (macro defined): BIST_MODE=1, ENABLE=1 for 8 beats, TREADY=1 → TDATA 0x0000..0x0007, TLAST on 0x0003 and 0x0007, DROP_COUNT=0.
